// File: rtl/cypher_access_ctrl.sv
// Shares one cypher_detector between two requesters: round-robin grant, nibble-serial
// code transfer, verdict collection, cypher programming and lockout after repeated failures.
module cypher_access_ctrl #(
  parameter logic [15:0] RESET_CYPHER = 16'h2601,
  parameter int          MAX_FAILS    = 3,
  parameter int          WAIT_CYCLES  = 4,
  parameter int          LOCK_CYCLES  = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] code0,
  input  logic [15:0] code1,
  input  logic        cfg_we,
  input  logic [15:0] cfg_cypher,
  output logic [15:0] det_cypher,
  output logic [3:0]  det_input,
  output logic        det_read,
  input  logic        det_detected,
  output logic        ack0,
  output logic        ack1,
  output logic        match,
  output logic        locked,
  output logic [3:0]  fail_count
);

  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [WW-1:0] WAIT_LAST  = WW'(WAIT_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_CYCLES - 1);
  localparam logic [3:0]    FAIL_LIMIT = 4'(MAX_FAILS);

  typedef enum logic [2:0] {IDLE, SEND, CHECK, RESP, LOCK} state_t;

  state_t        state_r;
  logic [15:0]   code_r;
  logic [1:0]    nib_r;
  logic [WW-1:0] wait_r;
  logic [LW-1:0] lock_r;
  logic          last_r;
  logic          side_r;
  logic          pick1_s;
  logic [15:0]   grant_code_s;

  function automatic logic [3:0] nibble_of(input logic [15:0] code, input logic [1:0] idx);
    case (idx)
      2'd0:    return code[15:12];
      2'd1:    return code[11:8];
      2'd2:    return code[7:4];
      2'd3:    return code[3:0];
      default: return 4'd0;
    endcase
  endfunction

  // Round-robin choice: on a tie, serve the side that was not granted last.
  always_comb begin
    pick1_s = 1'b0;
    if (req0 && req1) begin
      pick1_s = ~last_r;
    end else if (req1) begin
      pick1_s = 1'b1;
    end else begin
      pick1_s = 1'b0;
    end
    grant_code_s = pick1_s ? code1 : code0;
  end

  // Main control FSM with all outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      code_r     <= 16'd0;
      nib_r      <= 2'd0;
      wait_r     <= '0;
      lock_r     <= '0;
      last_r     <= 1'b1;
      side_r     <= 1'b0;
      det_cypher <= RESET_CYPHER;
      det_input  <= 4'd0;
      det_read   <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      match      <= 1'b0;
      locked     <= 1'b0;
      fail_count <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cfg_we) begin
            det_cypher <= cfg_cypher;
          end else if (req0 || req1) begin
            side_r    <= pick1_s;
            last_r    <= pick1_s;
            code_r    <= grant_code_s;
            det_read  <= 1'b1;
            det_input <= nibble_of(grant_code_s, 2'd0);
            nib_r     <= 2'd1;
            state_r   <= SEND;
          end else begin
            state_r <= IDLE;
          end
        end
        SEND: begin
          // nib_r wraps to 0 once the fourth nibble is on the bus.
          if (nib_r == 2'd0) begin
            det_read  <= 1'b0;
            det_input <= 4'd0;
            wait_r    <= '0;
            state_r   <= CHECK;
          end else begin
            det_input <= nibble_of(code_r, nib_r);
            nib_r     <= nib_r + 2'd1;
          end
        end
        CHECK: begin
          if (det_detected || (wait_r == WAIT_LAST)) begin
            ack0       <= ~side_r;
            ack1       <= side_r;
            match      <= det_detected;
            fail_count <= det_detected ? 4'd0 : (fail_count + 4'd1);
            state_r    <= RESP;
          end else begin
            wait_r <= wait_r + WW'(1);
          end
        end
        RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          match <= 1'b0;
          if (fail_count == FAIL_LIMIT) begin
            locked  <= 1'b1;
            lock_r  <= '0;
            state_r <= LOCK;
          end else begin
            state_r <= IDLE;
          end
        end
        LOCK: begin
          if (lock_r == LOCK_LAST) begin
            locked     <= 1'b0;
            fail_count <= 4'd0;
            state_r    <= IDLE;
          end else begin
            lock_r <= lock_r + LW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cypher_access_ctrl.sv
// Self-checking bench for cypher_access_ctrl: behavioural detector, scoreboard of expected
// acks, table-driven request vectors and hand-written timing/lockout/config/abort sequences.
module tb_cypher_access_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] code0 = 16'd0, code1 = 16'd0;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_cypher = 16'd0;
  logic [15:0] det_cypher;
  logic [3:0]  det_input;
  logic        det_read;
  logic        det_detected;
  logic        ack0, ack1, match, locked;
  logic [3:0]  fail_count;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  typedef struct packed {
    logic       side;
    logic       mt;
    logic [3:0] fc;
  } exp_t;

  typedef struct {
    logic        r0, r1;
    logic [15:0] c0, c1;
    int          n;
    exp_t        e0, e1;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[11];

  cypher_access_ctrl dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1),
    .code0(code0), .code1(code1), .cfg_we(cfg_we), .cfg_cypher(cfg_cypher),
    .det_cypher(det_cypher), .det_input(det_input), .det_read(det_read),
    .det_detected(det_detected), .ack0(ack0), .ack1(ack1), .match(match),
    .locked(locked), .fail_count(fail_count)
  );

  always #5 clock = ~clock;

  // Behavioural detector: flags when the last four nibbles read equal the cypher.
  logic [15:0] sh;
  logic        det;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      sh  <= 16'd0;
      det <= 1'b0;
    end else if (det_read) begin
      sh  <= {sh[11:0], det_input};
      det <= ({sh[11:0], det_input} == det_cypher);
    end else begin
      det <= 1'b0;
    end
  end
  assign det_detected = det;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every ack is matched against the oldest expected completion.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (ack0 && ack1) begin
        chk("two_acks", 32'd1, 32'd0);
      end else if (ack0 || ack1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ack_side", {31'd0, ack1}, {31'd0, e.side});
          chk("ack_match", {31'd0, match}, {31'd0, e.mt});
          chk("ack_fail_count", {28'd0, fail_count}, {28'd0, e.fc});
        end
      end else begin
        chk("match_idle", {31'd0, match}, 32'd0);
      end
    end
  end

  function automatic vec_t mk(input logic r0, input logic r1, input logic [15:0] c0,
                              input logic [15:0] c1, input int n, input exp_t e0, input exp_t e1);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.c0 = c0; v.c1 = c1; v.n = n; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int guard;
    @(negedge clock);
    code0 = v.c0; code1 = v.c1; req0 = v.r0; req1 = v.r1;
    exp_q.push_back(v.e0);
    if (v.n > 1) exp_q.push_back(v.e1);
    guard = 0;
    while ((req0 || req1) && guard < 100) begin
      @(negedge clock);
      guard++;
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
    end
    if (req0 || req1) begin
      chk("vec_timeout", {30'd0, req1, req0}, 32'd0);
      req0 = 1'b0; req1 = 1'b0;
    end
  endtask

  task automatic wait_ack0(input string name);
    int guard;
    guard = 0;
    while (req0 && guard < 40) begin
      @(negedge clock);
      guard++;
      if (ack0) req0 = 1'b0;
    end
    if (req0) begin
      chk(name, 32'd1, 32'd0);
      req0 = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] cyph;
    int lock_len;
    int acks_seen;

    tbl[0]  = mk(1'b1, 1'b0, 16'h2601, 16'h0000, 1, '{1'b0, 1'b1, 4'd0}, '{1'b0, 1'b0, 4'd0});
    tbl[1]  = mk(1'b0, 1'b1, 16'h0000, 16'h1234, 1, '{1'b1, 1'b0, 4'd1}, '{1'b0, 1'b0, 4'd0});
    tbl[2]  = mk(1'b1, 1'b1, 16'h2601, 16'h2601, 2, '{1'b0, 1'b1, 4'd0}, '{1'b1, 1'b1, 4'd0});
    tbl[3]  = mk(1'b1, 1'b1, 16'h1111, 16'h2601, 2, '{1'b0, 1'b0, 4'd1}, '{1'b1, 1'b1, 4'd0});
    tbl[4]  = mk(1'b0, 1'b1, 16'h0000, 16'h2601, 1, '{1'b1, 1'b1, 4'd0}, '{1'b0, 1'b0, 4'd0});
    tbl[5]  = mk(1'b1, 1'b0, 16'h2600, 16'h0000, 1, '{1'b0, 1'b0, 4'd1}, '{1'b0, 1'b0, 4'd0});
    tbl[6]  = mk(1'b0, 1'b1, 16'h0000, 16'h0000, 1, '{1'b1, 1'b0, 4'd2}, '{1'b0, 1'b0, 4'd0});
    tbl[7]  = mk(1'b1, 1'b0, 16'h2601, 16'h0000, 1, '{1'b0, 1'b1, 4'd0}, '{1'b0, 1'b0, 4'd0});
    tbl[8]  = mk(1'b1, 1'b0, 16'h0000, 16'h0000, 1, '{1'b0, 1'b0, 4'd1}, '{1'b0, 1'b0, 4'd0});
    tbl[9]  = mk(1'b1, 1'b0, 16'h1601, 16'h0000, 1, '{1'b0, 1'b0, 4'd2}, '{1'b0, 1'b0, 4'd0});
    tbl[10] = mk(1'b1, 1'b0, 16'h2602, 16'h0000, 1, '{1'b0, 1'b0, 4'd3}, '{1'b0, 1'b0, 4'd0});

    // Asynchronous reset between edges.
    @(negedge clock); @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_det_cypher", {16'd0, det_cypher}, 32'h2601);
    chk("rst_det_input", {28'd0, det_input}, 32'd0);
    chk("rst_det_read", {31'd0, det_read}, 32'd0);
    chk("rst_acks", {30'd0, ack1, ack0}, 32'd0);
    chk("rst_match", {31'd0, match}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_fail_count", {28'd0, fail_count}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    mon_en = 1'b1;

    // Match timing: nibbles in cycles 1-4, ack at cycle 6.
    cyph = 16'h2601;
    @(negedge clock);
    req0 = 1'b1; code0 = cyph;
    exp_q.push_back('{1'b0, 1'b1, 4'd0});
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      chk("match_det_read", {31'd0, det_read}, (i <= 4) ? 32'd1 : 32'd0);
      if (i <= 4) chk("match_det_input", {28'd0, det_input}, {28'd0, 4'((cyph >> (4 * (4 - i))) & 16'hF)});
      chk("match_ack0_cycle", {31'd0, ack0}, (i == 6) ? 32'd1 : 32'd0);
    end
    req0 = 1'b0;

    // Mismatch timing: ack at cycle 9.
    @(negedge clock);
    req1 = 1'b1; code1 = 16'h1234;
    exp_q.push_back('{1'b1, 1'b0, 4'd1});
    for (int i = 1; i <= 9; i++) begin
      @(negedge clock);
      chk("mismatch_ack1_cycle", {31'd0, ack1}, (i == 9) ? 32'd1 : 32'd0);
    end
    req1 = 1'b0;

    // Table: single requests, ties (order 0,1,0,1), fail counting up to lockout.
    for (int k = 0; k < 11; k++) run_vec(tbl[k]);

    // Lockout with req0 pending throughout.
    req0 = 1'b1; code0 = 16'h2601;
    exp_q.push_back('{1'b0, 1'b1, 4'd0});
    @(negedge clock);
    chk("lock_entry", {31'd0, locked}, 32'd1);
    chk("lock_fail_count", {28'd0, fail_count}, 32'd3);
    lock_len = 0;
    while (locked === 1'b1 && lock_len < 200) begin
      lock_len++;
      chk("lock_no_grant", {31'd0, det_read}, 32'd0);
      @(negedge clock);
    end
    chk("lock_len", lock_len, 32'd64);
    chk("unlock_fail_count", {28'd0, fail_count}, 32'd0);
    chk("unlock_idle", {31'd0, det_read}, 32'd0);
    @(negedge clock);
    chk("unlock_grant", {31'd0, det_read}, 32'd1);
    wait_ack0("unlock_ack_timeout");

    // Config write coinciding with a request delays the grant by one cycle.
    @(negedge clock);
    cfg_we = 1'b1; cfg_cypher = 16'hBEEF; req0 = 1'b1; code0 = 16'hBEEF;
    exp_q.push_back('{1'b0, 1'b1, 4'd0});
    @(negedge clock);
    cfg_we = 1'b0;
    chk("cfg_det_cypher", {16'd0, det_cypher}, 32'hBEEF);
    chk("cfg_no_grant", {31'd0, det_read}, 32'd0);
    @(negedge clock);
    chk("cfg_grant", {31'd0, det_read}, 32'd1);
    wait_ack0("cfg_ack_timeout");

    // Reset in SEND cycle 2 aborts the attempt.
    @(negedge clock);
    req1 = 1'b1; code1 = 16'hBEEF;
    @(negedge clock);
    @(negedge clock);
    chk("abort_in_send", {31'd0, det_read}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_det_read", {31'd0, det_read}, 32'd0);
    chk("abort_det_cypher", {16'd0, det_cypher}, 32'h2601);
    chk("abort_ack1", {31'd0, ack1}, 32'd0);
    req1 = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    acks_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (ack0 || ack1) acks_seen++;
    end
    chk("abort_no_ack", acks_seen, 32'd0);

    chk("sb_drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cypher_access_ctrl.md
# cypher_access_ctrl

Controller that owns one `cypher_detector` instance and shares it between two requesters. Each requester submits a complete 16-bit candidate code. The controller arbitrates round-robin, serialises the granted code into four nibble reads on the detector, collects the `cypher_detected` verdict, and returns a one-cycle acknowledge with the result. It also programs the detector's cypher register and enforces a lockout after repeated failed attempts.

## Interface
Parameters:
- `RESET_CYPHER`, default 16'h2601: value driven on `det_cypher` out of reset.
- `MAX_FAILS`, default 3: consecutive mismatches that trigger lockout; legal range 1..15.
- `WAIT_CYCLES`, default 4: maximum CHECK cycles spent waiting for `det_detected`; must be ≥1.
- `LOCK_CYCLES`, default 64: duration of lockout, in cycles.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces all state and outputs to their reset values immediately.
- `req0`, `req1`  in  1  request; held high until the matching ack.
- `code0`, `code1`  in  16  candidate code; must be stable while its req is high.
- `cfg_we`  in  1  cypher write strobe.
- `cfg_cypher`  in  16  new cypher value.
- `det_cypher`  out  16  to detector `cypher`.
- `det_input`  out  4  to detector `input`.
- `det_read`  out  1  to detector `read`.
- `det_detected`  in  1  from detector `cypher_detected`.
- `ack0`, `ack1`  out  1  one-cycle completion pulse per requester.
- `match`  out  1  result; valid only while an ack is high, 0 otherwise.
- `locked`  out  1  high throughout LOCK.
- `fail_count`  out  4  current count of consecutive mismatches.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE
  - `det_cypher`=RESET_CYPHER
  - `det_input`=0, `det_read`=0
  - `ack0`=`ack1`=0, `match`=0
  - `locked`=0, `fail_count`=0
  - round-robin pointer favours req0.
- Detector contract: the detector compares the last four nibbles read, first-read nibble mapping to `cypher[15:12]`.
- IDLE:
  - If `cfg_we`=1, load `cfg_cypher` into `det_cypher`. No grant occurs in that cycle; pending requests wait one cycle.
  - Otherwise, if any req is high, grant one and capture its code.
  - If both are high, grant the side not granted last. After reset, req0 wins the first tie.
  - `cfg_we` outside IDLE is ignored.
- SEND: 4 cycles.
  - `det_read`=1.
  - `det_input` = code[15:12], [11:8], [7:4], [3:0], in that order.
- CHECK:
  - `det_read`=0, `det_input`=0.
  - Sample `det_detected` each cycle. The first high sample → RESP with match=1.
  - After WAIT_CYCLES samples with no high → RESP with match=0.
- RESP: 1 cycle.
  - The granted requester's ack is high; `match` shows the result.
  - On match: `fail_count`←0, next state IDLE.
  - On mismatch: `fail_count`+1. If the new value equals MAX_FAILS, next state LOCK; otherwise IDLE.
- LOCK:
  - `locked`=1; no grants are made; requests stay pending.
  - After LOCK_CYCLES cycles: `fail_count`←0, `locked`←0, next state IDLE.
- A req dropped before grant is never served. A req dropped after grant is still completed; its ack fires anyway.
- Reset asserted mid-SEND or mid-CHECK aborts the attempt: `det_read` drops at once, no ack is issued, and the cypher returns to RESET_CYPHER.

## Timing
- Cycle 0 = the IDLE cycle in which the grant is sampled.
  - Cycles 1–4: SEND, `det_read`=1.
  - Cycle 5: first CHECK cycle.
- Fastest ack is cycle 6 (detected in the first CHECK cycle).
- A mismatch acks at cycle 5+WAIT_CYCLES; with the default that is cycle 9.
- The next grant is possible in the cycle after RESP, so back-to-back attempts are 7 cycles apart at minimum.
- A `cfg_we` write is visible on `det_cypher` in the cycle after it is sampled.
- LOCK is entered the cycle after the failing RESP. The first grant after lockout occurs LOCK_CYCLES+1 cycles after LOCK entry.
- At most one of `ack0`/`ack1` is high in any cycle.

## Test plan
- Reset: assert `reset` asynchronously between clock edges → all outputs go to their reset values immediately, with `det_cypher`=16'h2601.
- Match: req0 with code0=16'h2601, against a behavioural detector → `det_input` reads 2,6,0,1 in cycles 1–4; `ack0`=1 and `match`=1 at cycle 6; `fail_count`=0.
- Mismatch: req1 with code1=16'h1234 → `ack1`=1 and `match`=0 at cycle 9; `fail_count`=1.
- Arbitration: req0 and req1 held high together, twice → grant order 0,1,0,1; never two acks in the same cycle.
- Lockout: three consecutive mismatches → `locked`=1 for 64 cycles, a pending req0 is not granted, `fail_count`=3; then `fail_count`=0 and req0 is granted.
- Config and abort:
  - `cfg_we` with 16'hBEEF in the same cycle as req0 → `det_cypher`=16'hBEEF, grant one cycle later, code 16'hBEEF acks with `match`=1.
  - `reset` pulsed in SEND cycle 2 → no ack, `det_read`=0, `det_cypher`=16'h2601.
